// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU/WB/divide codes and the control bundle type
package ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_AND    = 5'b00010;
  localparam logic [4:0] ALU_OR     = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SLL    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_SLT    = 5'b01000;
  localparam logic [4:0] ALU_SLTU   = 5'b01001;
  localparam logic [4:0] ALU_LUI    = 5'b01010;
  localparam logic [4:0] ALU_MUL    = 5'b01011;
  localparam logic [4:0] ALU_MULH   = 5'b01100;
  localparam logic [4:0] ALU_MULHSU = 5'b01101;
  localparam logic [4:0] ALU_MULHU  = 5'b01110;
  localparam logic [4:0] ALU_NONE   = 5'b11111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] DIV_DIV  = 2'b00;
  localparam logic [1:0] DIV_DIVU = 2'b01;
  localparam logic [1:0] DIV_REM  = 2'b10;
  localparam logic [1:0] DIV_REMU = 2'b11;

  typedef struct packed {
    logic       reg_wen;
    logic       mem_w;
    logic       mem_read;
    logic       b_sel;
    logic       a_sel;
    logic       br_un;
    logic       branch;
    logic       is_jalr;
    logic       redirect;
    logic       is_div;
    logic       trap_req;
    logic       illegal;
    logic [1:0] div_mode;
    logic [1:0] wb_sel;
    logic [4:0] alu_sel;
  } ctrl_t;

  // Base integer op selected by funct3, shared by OP and OP-IMM.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_comb.sv
// rtl/ctrl_decode_stage_comb.sv - combinational instruction to control bundle decoder
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit HAS_M = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       bad;
  ctrl_t      c;
  logic       unused_fields;

  assign opc = instr[6:0];
  assign f7  = instr[31:25];
  assign f3  = instr[14:12];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    c   = '0;
    bad = 1'b0;
    case (opc)
      OP: begin
        c.reg_wen = 1'b1;
        c.wb_sel  = WB_ALU;
        if (f7 == F7_BASE) begin
          c.alu_sel = alu_from_f3(f3);
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      c.alu_sel = ALU_SUB;
          else if (f3 == 3'b101) c.alu_sel = ALU_SRA;
          else                   bad = 1'b1;
        end else if (f7 == F7_MULDIV && HAS_M) begin
          case (f3)
            3'b000: c.alu_sel = ALU_MUL;
            3'b001: c.alu_sel = ALU_MULH;
            3'b010: c.alu_sel = ALU_MULHSU;
            3'b011: c.alu_sel = ALU_MULHU;
            default: begin
              // funct3[1:0] of DIV/DIVU/REM/REMU maps directly onto div_mode
              c.is_div   = 1'b1;
              c.alu_sel  = ALU_NONE;
              c.div_mode = f3[1:0];
            end
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        c.reg_wen = 1'b1;
        c.b_sel   = 1'b1;
        c.wb_sel  = WB_ALU;
        c.alu_sel = alu_from_f3(f3);
        if (f3 == 3'b001 && f7 != F7_BASE) bad = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)        c.alu_sel = ALU_SRA;
          else if (f7 != F7_BASE)  bad = 1'b1;
        end
      end
      LOAD: begin
        c.reg_wen  = 1'b1;
        c.mem_read = 1'b1;
        c.b_sel    = 1'b1;
        c.wb_sel   = WB_MEM;
        c.alu_sel  = ALU_ADD;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
      end
      STORE: begin
        c.mem_w   = 1'b1;
        c.b_sel   = 1'b1;
        c.alu_sel = ALU_ADD;
        if (f3 > 3'b010) bad = 1'b1;
      end
      AUIPC: begin
        c.reg_wen = 1'b1;
        c.a_sel   = 1'b1;
        c.b_sel   = 1'b1;
        c.wb_sel  = WB_ALU;
        c.alu_sel = ALU_ADD;
      end
      LUI: begin
        c.reg_wen = 1'b1;
        c.b_sel   = 1'b1;
        c.wb_sel  = WB_ALU;
        c.alu_sel = ALU_LUI;
      end
      JAL: begin
        c.reg_wen  = 1'b1;
        c.a_sel    = 1'b1;
        c.b_sel    = 1'b1;
        c.wb_sel   = WB_PC4;
        c.redirect = 1'b1;
        c.alu_sel  = ALU_ADD;
      end
      JALR: begin
        c.reg_wen  = 1'b1;
        c.is_jalr  = 1'b1;
        c.b_sel    = 1'b1;
        c.wb_sel   = WB_PC4;
        c.redirect = 1'b1;
        c.alu_sel  = ALU_ADD;
        if (f3 != 3'b000) bad = 1'b1;
      end
      BRANCH: begin
        c.branch  = 1'b1;
        c.a_sel   = 1'b1;
        c.b_sel   = 1'b1;
        c.alu_sel = ALU_ADD;
        c.br_un   = f3[2] & f3[1];
        if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      end
      SYSTEM: begin
        c.trap_req = 1'b1;
        c.alu_sel  = ALU_NONE;
      end
      default: bad = 1'b1;
    endcase

    // An illegal encoding collapses to a pure trap with no side effects.
    if (bad || instr[1:0] != 2'b11) begin
      c          = '0;
      c.illegal  = 1'b1;
      c.trap_req = 1'b1;
      c.alu_sel  = ALU_NONE;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered decode stage with handshake, flush and divider interlock
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit HAS_M      = 1'b1,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            regWEn,
  output logic            MemW,
  output logic            memRead,
  output logic            BSel,
  output logic            ASel,
  output logic            BrUn,
  output logic            branch,
  output logic            is_jalr,
  output logic            redirect,
  output logic            is_div,
  output logic            trapReq,
  output logic            illegal,
  output logic [1:0]      div_mode,
  output logic [1:0]      WBSel,
  output logic [4:0]      ALUSel,
  output logic            div_busy
);

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES);

  ctrl_t           dec;
  ctrl_t           ctrl_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [7:0]      div_cnt;
  logic            accept;
  logic            fire;

  ctrl_decode_comb #(.HAS_M(HAS_M)) u_dec (
    .instr (instr),
    .ctrl  (dec)
  );

  assign div_busy  = (div_cnt != 8'd0);
  assign out_valid = valid_q & ~div_busy;
  assign in_ready  = ~flush_i & (~valid_q | (out_ready & ~div_busy));
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec;
      pc_q    <= pc;
      instr_q <= instr;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

  // Flush deliberately leaves the counter alone: an issued divide still occupies the unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 8'd0;
    end else if (fire && ctrl_q.is_div) begin
      div_cnt <= DIV_LOAD;
    end else if (div_busy) begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign regWEn    = ctrl_q.reg_wen;
  assign MemW      = ctrl_q.mem_w;
  assign memRead   = ctrl_q.mem_read;
  assign BSel      = ctrl_q.b_sel;
  assign ASel      = ctrl_q.a_sel;
  assign BrUn      = ctrl_q.br_un;
  assign branch    = ctrl_q.branch;
  assign is_jalr   = ctrl_q.is_jalr;
  assign redirect  = ctrl_q.redirect;
  assign is_div    = ctrl_q.is_div;
  assign trapReq   = ctrl_q.trap_req;
  assign illegal   = ctrl_q.illegal;
  assign div_mode  = ctrl_q.div_mode;
  assign WBSel     = ctrl_q.wb_sel;
  assign ALUSel    = ctrl_q.alu_sel;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - directed checks of the decode stage with and without the M extension
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush_i, out_ready;
  logic [31:0] instr, pc;

  logic        in_ready_a, out_valid_a, div_busy_a;
  logic [31:0] out_pc_a, out_instr_a;
  logic        rw_a, mw_a, mr_a, bs_a, as_a, bu_a, br_a, jr_a, rd_a, dv_a, tr_a, il_a;
  logic [1:0]  dm_a, wb_a;
  logic [4:0]  alu_a;

  logic        in_ready_b, out_valid_b, div_busy_b;
  logic [31:0] out_pc_b, out_instr_b;
  logic        rw_b, mw_b, mr_b, bs_b, as_b, bu_b, br_b, jr_b, rd_b, dv_b, tr_b, il_b;
  logic [1:0]  dm_b, wb_b;
  logic [4:0]  alu_b;

  logic [20:0] ctl_a, ctl_b;
  assign ctl_a = {rw_a, mw_a, mr_a, bs_a, as_a, bu_a, br_a, jr_a, rd_a, dv_a, tr_a, il_a, dm_a, wb_a, alu_a};
  assign ctl_b = {rw_b, mw_b, mr_b, bs_b, as_b, bu_b, br_b, jr_b, rd_b, dv_b, tr_b, il_b, dm_b, wb_b, alu_b};

  always #5 clk = ~clk;

  ctrl_decode_stage #(.XLEN(32), .HAS_M(1'b1), .DIV_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr), .pc(pc),
    .flush_i(flush_i), .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
    .out_instr(out_instr_a), .regWEn(rw_a), .MemW(mw_a), .memRead(mr_a), .BSel(bs_a), .ASel(as_a),
    .BrUn(bu_a), .branch(br_a), .is_jalr(jr_a), .redirect(rd_a), .is_div(dv_a), .trapReq(tr_a),
    .illegal(il_a), .div_mode(dm_a), .WBSel(wb_a), .ALUSel(alu_a), .div_busy(div_busy_a)
  );

  ctrl_decode_stage #(.XLEN(32), .HAS_M(1'b0), .DIV_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .instr(instr), .pc(pc),
    .flush_i(flush_i), .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
    .out_instr(out_instr_b), .regWEn(rw_b), .MemW(mw_b), .memRead(mr_b), .BSel(bs_b), .ASel(as_b),
    .BrUn(bu_b), .branch(br_b), .is_jalr(jr_b), .redirect(rd_b), .is_div(dv_b), .trapReq(tr_b),
    .illegal(il_b), .div_mode(dm_b), .WBSel(wb_b), .ALUSel(alu_b), .div_busy(div_busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] ex(input logic rw, mw, mr, bs, as, bu, br, jr, rd, dv, tr, il,
                                     input logic [1:0] dm, wb, input logic [4:0] alu);
    return {rw, mw, mr, bs, as, bu, br, jr, rd, dv, tr, il, dm, wb, alu};
  endfunction

  // Present one instruction for a single cycle; returns at the following posedge + 1.
  task automatic issue(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  localparam int NV = 11;
  logic [31:0] t_instr [NV];
  logic [20:0] t_exp_a [NV];
  logic [20:0] t_exp_b [NV];
  logic [20:0] ill;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_DIV  = 32'h0220C0B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_JAL  = 32'h0080006F;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0;

    ill = ex(0,0,0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b00, 5'b11111);
    t_instr[0]  = I_ADD;        t_exp_a[0]  = ex(1,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 5'b00000); t_exp_b[0] = t_exp_a[0];
    t_instr[1]  = 32'h022080B3; t_exp_a[1]  = ex(1,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 5'b01011); t_exp_b[1] = ill;
    t_instr[2]  = 32'h0000007F; t_exp_a[2]  = ill; t_exp_b[2] = ill;
    t_instr[3]  = 32'h003100B0; t_exp_a[3]  = ill; t_exp_b[3] = ill;
    t_instr[4]  = 32'h403170B3; t_exp_a[4]  = ill; t_exp_b[4] = ill;
    t_instr[5]  = 32'h40311093; t_exp_a[5]  = ill; t_exp_b[5] = ill;
    t_instr[6]  = 32'h40315093; t_exp_a[6]  = ex(1,0,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 5'b00111); t_exp_b[6] = t_exp_a[6];
    t_instr[7]  = 32'h0020A463; t_exp_a[7]  = ill; t_exp_b[7] = ill;
    t_instr[8]  = 32'h00000073; t_exp_a[8]  = ex(0,0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 5'b11111); t_exp_b[8] = t_exp_a[8];
    t_instr[9]  = I_SUB;        t_exp_a[9]  = ex(1,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 5'b00001); t_exp_b[9] = t_exp_a[9];
    t_instr[10] = 32'h0220F0B3; t_exp_a[10] = ex(1,0,0,0,0,0,0,0,0,1,0,0, 2'b11, 2'b01, 5'b11111); t_exp_b[10] = ill;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("rst_div_busy", {31'b0, div_busy_a}, 32'd0);
    check("rst_ctl", {11'b0, ctl_a}, 32'd0);
    check("rst_out_pc", out_pc_a, 32'd0);
    check("rst_out_instr", out_instr_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single-instruction decode vectors, out_ready=1
    for (int i = 0; i < NV; i++) begin
      issue(t_instr[i], 32'h1000 + 32'(i * 4));
      @(negedge clk);
      check($sformatf("vec%0d_valid_a", i), {31'b0, out_valid_a}, 32'd1);
      check($sformatf("vec%0d_ctl_a", i), {11'b0, ctl_a}, {11'b0, t_exp_a[i]});
      check($sformatf("vec%0d_ctl_b", i), {11'b0, ctl_b}, {11'b0, t_exp_b[i]});
      check($sformatf("vec%0d_pc_a", i), out_pc_a, 32'h1000 + 32'(i * 4));
      check($sformatf("vec%0d_instr_a", i), out_instr_a, t_instr[i]);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10 && div_busy_a; k++) begin
      @(posedge clk); #1;
    end
    check("remu_drained", {31'b0, div_busy_a}, 32'd0);

    // DIV followed by ADDI: interlock masks the ADDI for DIV_CYCLES cycles
    in_valid = 1'b1; instr = I_DIV; pc = 32'h2000;
    @(posedge clk); #1;
    instr = I_ADDI; pc = 32'h2004;
    @(negedge clk);
    check("div_valid", {31'b0, out_valid_a}, 32'd1);
    check("div_ctl_a", {11'b0, ctl_a}, {11'b0, ex(1,0,0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b01, 5'b11111)});
    check("div_ctl_b_illegal", {11'b0, ctl_b}, {11'b0, ill});
    check("div_in_ready", {31'b0, in_ready_a}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("div_busy_t%0d", k), {31'b0, div_busy_a}, 32'd1);
      check($sformatf("div_mask_t%0d", k), {31'b0, out_valid_a}, 32'd0);
      check($sformatf("div_in_ready_t%0d", k), {31'b0, in_ready_a}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("div_t5_busy", {31'b0, div_busy_a}, 32'd0);
    check("div_t5_valid", {31'b0, out_valid_a}, 32'd1);
    check("addi_ctl", {11'b0, ctl_a}, {11'b0, ex(1,0,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 5'b00000)});
    check("addi_pc", out_pc_a, 32'h2004);
    @(posedge clk); #1;

    // BLTU held by out_ready=0 for three cycles
    out_ready = 1'b0;
    issue(I_BLTU, 32'h200);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; instr = I_ADD; pc = 32'h204;
      @(negedge clk);
      check($sformatf("bltu_hold%0d_valid", k), {31'b0, out_valid_a}, 32'd1);
      check($sformatf("bltu_hold%0d_ctl", k), {11'b0, ctl_a}, {11'b0, ex(0,0,0,1,1,1,1,0,0,0,0,0, 2'b00, 2'b00, 5'b00000)});
      check($sformatf("bltu_hold%0d_pc", k), out_pc_a, 32'h200);
      check($sformatf("bltu_hold%0d_in_ready", k), {31'b0, in_ready_a}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bltu_release_valid", {31'b0, out_valid_a}, 32'd1);
    check("bltu_release_instr", out_instr_a, I_BLTU);
    @(posedge clk); #1;
    @(negedge clk);
    check("bltu_drained", {31'b0, out_valid_a}, 32'd0);
    @(posedge clk); #1;

    // flush kills the held bundle and drops the same-cycle input
    out_ready = 1'b0;
    issue(I_ADD, 32'h300);
    in_valid = 1'b1; instr = I_SUB; pc = 32'h304; flush_i = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'b0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("flush_not_accepted", out_instr_a, I_ADD);
    @(posedge clk); #1;

    // flush during div_busy: counter keeps running, masked ADDI is killed
    in_valid = 1'b1; instr = I_DIV; pc = 32'h400;
    @(posedge clk); #1;
    instr = I_ADDI; pc = 32'h404;
    @(posedge clk); #1;
    in_valid = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    check("fdiv_t1_busy", {31'b0, div_busy_a}, 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("fdiv_t%0d_busy", k), {31'b0, div_busy_a}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("fdiv_t5_busy", {31'b0, div_busy_a}, 32'd0);
    check("fdiv_t5_valid", {31'b0, out_valid_a}, 32'd0);
    @(posedge clk); #1;

    // JAL
    issue(I_JAL, 32'h500);
    @(negedge clk);
    check("jal_valid", {31'b0, out_valid_a}, 32'd1);
    check("jal_redirect", {31'b0, rd_a}, 32'd1);
    check("jal_wbsel", {30'b0, wb_a}, 32'd2);
    check("jal_asel", {31'b0, as_a}, 32'd1);
    check("jal_bsel", {31'b0, bs_a}, 32'd1);
    check("jal_illegal", {31'b0, il_a}, 32'd0);
    check("jal_trap", {31'b0, tr_a}, 32'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
